// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dma_pkg
//  Description : Shared types and helpers for the DMA read streamer:
//                FSM state encoding, transfer descriptor and the
//                beats-to-boundary helper used by the burst sizer.
//  Revision    : 1.0  initial release
// ============================================================================
package dma_pkg;

    localparam int DMA_ADDR_W = 32;
    localparam int DMA_CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CALC       = 3'd1,
        WAIT_SPACE = 3'd2,
        REQ        = 3'd3,
        DATA       = 3'd4,
        DONE       = 3'd5
    } dma_state_t;

    typedef struct packed {
        logic [DMA_ADDR_W-1:0] addr;
        logic [DMA_CNT_W-1:0]  num_words;
    } dma_desc_t;

    // Beats left before the next max_burst-word aligned address, given the
    // word offset inside the current max_burst window (max_burst is 2^n).
    function automatic int unsigned beats_to_boundary(input int unsigned word_off,
                                                      input int unsigned max_burst);
        return max_burst - (word_off & (max_burst - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_burst_calc.sv
`default_nettype none
// ============================================================================
//  Module      : dma_burst_calc
//  Description : Combinational burst sizer. blen = min(MAX_BURST, remaining
//                words, words up to the next MAX_BURST-word boundary).
//  Ports       : word_off_i - word offset of the current address inside its
//                             MAX_BURST-word window
//                remain_i   - words still to transfer
//                blen_o     - beats in the next burst (1..MAX_BURST)
//  Revision    : 1.0  initial release
// ============================================================================
module dma_burst_calc
    import dma_pkg::*;
#(
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 16
) (
    input  logic [$clog2(MAX_BURST)-1:0] word_off_i,
    input  logic [CNT_W-1:0]             remain_i,
    output logic [$clog2(MAX_BURST):0]   blen_o
);

    localparam int c_LB = $clog2(MAX_BURST);
    typedef logic [c_LB:0] blen_t;

    blen_t w_to_bnd;
    blen_t w_rem_clip;

    // Both terms are already bounded by MAX_BURST, so the min of the two
    // covers the MAX_BURST term as well.
    always_comb begin
        w_to_bnd = blen_t'(beats_to_boundary(32'(word_off_i), 32'(MAX_BURST)));
        if (remain_i < CNT_W'(MAX_BURST)) begin
            w_rem_clip = remain_i[c_LB:0];
        end else begin
            w_rem_clip = blen_t'(MAX_BURST);
        end
        blen_o = (w_rem_clip < w_to_bnd) ? w_rem_clip : w_to_bnd;
    end

endmodule
`default_nettype wire

// File: rtl/dma_rd_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : dma_rd_streamer
//  Description : Read-side DMA stage. Splits one descriptor into boundary-
//                aligned bursts, issues each only when the downstream FIFO
//                has room for the whole burst, and pushes returned beats
//                straight into the FIFO.
//  Ports       : start_i/src_addr_i/num_words_i/abort_i - descriptor control
//                busy_o/done_o/err_o/aborted_o           - status
//                rd_req_*  - burst request (valid/ready)
//                rd_rsp_*  - response beats (no backpressure)
//                fifo_*    - FIFO write port and free-slot count
//  Revision    : 1.0  initial release
// ============================================================================
module dma_rd_streamer
    import dma_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ADDR_W    = DMA_ADDR_W,
    parameter int SLOTS     = 16,
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = DMA_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic [ADDR_W-1:0]            src_addr_i,
    input  logic [CNT_W-1:0]             num_words_i,
    input  logic                         abort_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o,
    output logic                         aborted_o,
    output logic                         rd_req_valid_o,
    input  logic                         rd_req_ready_i,
    output logic [ADDR_W-1:0]            rd_req_addr_o,
    output logic [$clog2(MAX_BURST)-1:0] rd_req_len_o,
    input  logic                         rd_rsp_valid_i,
    input  logic [WIDTH-1:0]             rd_rsp_data_i,
    input  logic                         rd_rsp_err_i,
    output logic                         fifo_write_o,
    output logic [WIDTH-1:0]             fifo_data_o,
    input  logic [$clog2(SLOTS):0]       fifo_free_i
);

    localparam int c_BYTES  = WIDTH / 8;
    localparam int c_BSH    = $clog2(c_BYTES);
    localparam int c_LB     = $clog2(MAX_BURST);
    localparam int c_FREE_W = $clog2(SLOTS) + 1;

    typedef logic [c_LB:0]   blen_t;
    typedef logic [c_LB-1:0] len_t;
    localparam blen_t c_ONE = blen_t'(1);

    dma_state_t        r_state;
    dma_state_t        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_remain;
    blen_t             r_blen;
    blen_t             r_beat;
    logic              r_err;
    logic              r_abort;
    blen_t             w_blen;
    dma_desc_t         w_desc;

    assign w_desc = '{addr: src_addr_i, num_words: num_words_i};

    dma_burst_calc #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_burst_calc (
        .word_off_i (r_addr[c_BSH +: c_LB]),
        .remain_i   (r_remain),
        .blen_o     (w_blen)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_remain <= '0;
            r_blen   <= '0;
            r_beat   <= '0;
            r_err    <= 1'b0;
            r_abort  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_addr   <= w_desc.addr;
                        r_remain <= w_desc.num_words;
                        r_err    <= 1'b0;
                        r_abort  <= 1'b0;
                    end
                end
                CALC: begin
                    r_blen <= w_blen;
                    if (abort_i) r_abort <= 1'b1;
                end
                WAIT_SPACE: begin
                    if (abort_i) r_abort <= 1'b1;
                end
                REQ: begin
                    // Abort here is only remembered; the held request must
                    // still complete its handshake and the burst be drained.
                    if (abort_i) r_abort <= 1'b1;
                    if (rd_req_ready_i) begin
                        r_beat   <= r_blen;
                        r_addr   <= r_addr + (ADDR_W'(r_blen) << c_BSH);
                        r_remain <= r_remain - CNT_W'(r_blen);
                    end
                end
                DATA: begin
                    if (abort_i) r_abort <= 1'b1;
                    if (rd_rsp_valid_i) begin
                        r_beat <= r_beat - c_ONE;
                        if (rd_rsp_err_i) r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next         = r_state;
        busy_o         = 1'b0;
        done_o         = 1'b0;
        err_o          = 1'b0;
        aborted_o      = 1'b0;
        rd_req_valid_o = 1'b0;
        rd_req_addr_o  = '0;
        rd_req_len_o   = '0;
        fifo_write_o   = 1'b0;
        fifo_data_o    = '0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_next = (w_desc.num_words == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                busy_o = 1'b1;
                w_next = abort_i ? DONE : WAIT_SPACE;
            end
            WAIT_SPACE: begin
                busy_o = 1'b1;
                // Sole FIFO writer with one burst outstanding: free space
                // seen here cannot shrink before the burst lands.
                if (abort_i) begin
                    w_next = DONE;
                end else if (fifo_free_i >= c_FREE_W'(r_blen)) begin
                    w_next = REQ;
                end
            end
            REQ: begin
                busy_o         = 1'b1;
                rd_req_valid_o = 1'b1;
                rd_req_addr_o  = r_addr;
                rd_req_len_o   = len_t'(r_blen - c_ONE);
                if (rd_req_ready_i) w_next = DATA;
            end
            DATA: begin
                busy_o = 1'b1;
                if (rd_rsp_valid_i) begin
                    // Once an error beat is seen the rest of the burst is
                    // swallowed so no data after the error reaches the FIFO.
                    if (!rd_rsp_err_i && !r_err) begin
                        fifo_write_o = 1'b1;
                        fifo_data_o  = rd_rsp_data_i;
                    end
                    if (r_beat == c_ONE) begin
                        if (r_err || rd_rsp_err_i || r_abort || abort_i || (r_remain == '0)) begin
                            w_next = DONE;
                        end else begin
                            w_next = CALC;
                        end
                    end
                end
            end
            DONE: begin
                done_o    = 1'b1;
                err_o     = r_err;
                aborted_o = r_abort;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_rd_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dma_rd_streamer
//  Description : Directed bench for dma_rd_streamer: a table of descriptors
//                with hand-computed bursts/pushes plus hand-written
//                sequences for back-pressure, abort, zero-length and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dma_rd_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [31:0] src_addr_i;
    logic [15:0] num_words_i;
    logic        abort_i;
    logic        busy_o, done_o, err_o, aborted_o;
    logic        rd_req_valid_o;
    logic        rd_req_ready_i;
    logic [31:0] rd_req_addr_o;
    logic [2:0]  rd_req_len_o;
    logic        rd_rsp_valid_i;
    logic [31:0] rd_rsp_data_i;
    logic        rd_rsp_err_i;
    logic        fifo_write_o;
    logic [31:0] fifo_data_o;
    logic [4:0]  fifo_free_i;

    dma_rd_streamer #(
        .WIDTH(32), .ADDR_W(32), .SLOTS(16), .MAX_BURST(8), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .start_i(start_i), .src_addr_i(src_addr_i), .num_words_i(num_words_i),
        .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .aborted_o(aborted_o),
        .rd_req_valid_o(rd_req_valid_o), .rd_req_ready_i(rd_req_ready_i),
        .rd_req_addr_o(rd_req_addr_o), .rd_req_len_o(rd_req_len_o),
        .rd_rsp_valid_i(rd_rsp_valid_i), .rd_rsp_data_i(rd_rsp_data_i),
        .rd_rsp_err_i(rd_rsp_err_i),
        .fifo_write_o(fifo_write_o), .fifo_data_o(fifo_data_o),
        .fifo_free_i(fifo_free_i)
    );

    always #5 clk = ~clk;

    // ---------------- memory model and output monitor ----------------
    logic [31:0] req_addr_q[$];
    int          req_len_q[$];
    logic [31:0] push_q[$];
    int          n_done = 0;
    logic        last_err = 1'b0;
    logic        last_ab  = 1'b0;
    logic [31:0] rsp_addr = 32'h0;
    int          rsp_left = 0;
    int          xfer_beat = 0;
    int          err_beat = 0;

    function automatic logic [31:0] mkdata(input logic [31:0] a);
        return a ^ 32'hC0DE_5A00;
    endfunction

    always @(negedge clk) begin
        rd_rsp_valid_i = 1'b0;
        rd_rsp_err_i   = 1'b0;
        rd_rsp_data_i  = 32'h0;
        if (rst) begin
            rsp_left = 0;
        end else if (rsp_left > 0) begin
            xfer_beat++;
            rd_rsp_valid_i = 1'b1;
            rd_rsp_data_i  = mkdata(rsp_addr);
            rd_rsp_err_i   = (xfer_beat == err_beat);
            rsp_addr       = rsp_addr + 32'd4;
            rsp_left--;
        end
        if (!rst && rd_req_valid_o && rd_req_ready_i) begin
            req_addr_q.push_back(rd_req_addr_o);
            req_len_q.push_back(int'(rd_req_len_o));
            rsp_addr = rd_req_addr_o;
            rsp_left = int'(rd_req_len_o) + 1;
        end
        #1;
        if (fifo_write_o) push_q.push_back(fifo_data_o);
        if (done_o) begin
            n_done++;
            last_err = err_o;
            last_ab  = aborted_o;
        end
    end

    // ---------------- checking helpers ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Test process acts 2 time units after the falling edge, after the
    // monitor has sampled.
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_logs();
        req_addr_q.delete();
        req_len_q.delete();
        push_q.delete();
        xfer_beat = 0;
    endtask

    task automatic start_xfer(input logic [31:0] a, input int w, input int f, input int eb);
        clear_logs();
        err_beat    = eb;
        fifo_free_i = 5'(f);
        src_addr_i  = a;
        num_words_i = 16'(w);
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0, input int limit);
        int c;
        c = 0;
        while (n_done == d0 && c < limit) begin
            tick();
            c++;
        end
        chk({name, " timeout"}, 32'(n_done != d0), 32'd1);
    endtask

    task automatic chk_pushes(input string name, input logic [31:0] a, input int n);
        chk({name, " npush"}, 32'(push_q.size()), 32'(n));
        for (int i = 0; i < n && i < push_q.size(); i++)
            chk($sformatf("%s push%0d", name, i), push_q[i], mkdata(a + 32'(4 * i)));
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [31:0]      addr;
        int               words;
        int               free;
        int               eb;
        int               npush;
        int               nreq;
        logic [2:0][31:0] ra;
        logic [2:0][2:0]  rl;
        logic             err;
    } vec_t;

    function automatic vec_t mkv(input logic [31:0] a, input int w, input int f, input int eb,
                                 input int np, input int nr,
                                 input logic [31:0] a0, input int l0,
                                 input logic [31:0] a1, input int l1,
                                 input logic [31:0] a2, input int l2,
                                 input logic e);
        vec_t v;
        v.addr = a; v.words = w; v.free = f; v.eb = eb; v.npush = np; v.nreq = nr;
        v.ra[0] = a0; v.ra[1] = a1; v.ra[2] = a2;
        v.rl[0] = 3'(l0); v.rl[1] = 3'(l1); v.rl[2] = 3'(l2);
        v.err = e;
        return v;
    endfunction

    vec_t vt[6];

    initial begin
        int d0;
        int c;
        vt[0] = mkv(32'h1000, 20, 16, 0, 20, 3, 32'h1000, 7, 32'h1020, 7, 32'h1040, 3, 1'b0);
        vt[1] = mkv(32'h1018,  8, 16, 0,  8, 2, 32'h1018, 1, 32'h1020, 5, 32'h0, 0, 1'b0);
        vt[2] = mkv(32'h1000,  8, 16, 3,  2, 1, 32'h1000, 7, 32'h0, 0, 32'h0, 0, 1'b1);
        vt[3] = mkv(32'h2004,  3, 16, 0,  3, 1, 32'h2004, 2, 32'h0, 0, 32'h0, 0, 1'b0);
        vt[4] = mkv(32'hFFFF_FFF8, 4, 16, 0, 4, 2, 32'hFFFF_FFF8, 1, 32'h0, 1, 32'h0, 0, 1'b0);
        vt[5] = mkv(32'h3000,  9,  8, 0,  9, 2, 32'h3000, 7, 32'h3020, 0, 32'h0, 0, 1'b0);

        rst = 1'b1; start_i = 1'b0; src_addr_i = '0; num_words_i = '0; abort_i = 1'b0;
        rd_req_ready_i = 1'b1; fifo_free_i = 5'd16;
        repeat (3) tick();
        chk("reset busy",  32'(busy_o), 32'd0);
        chk("reset done",  32'(done_o), 32'd0);
        chk("reset reqv",  32'(rd_req_valid_o), 32'd0);
        chk("reset fifow", 32'(fifo_write_o), 32'd0);
        chk("reset raddr", rd_req_addr_o, 32'd0);
        chk("reset rlen",  32'(rd_req_len_o), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            d0 = n_done;
            start_xfer(vt[i].addr, vt[i].words, vt[i].free, vt[i].eb);
            chk({nm, " busy"}, 32'(busy_o), 32'd1);
            wait_done(nm, d0, 400);
            tick();
            chk({nm, " nreq"}, 32'(req_addr_q.size()), 32'(vt[i].nreq));
            for (int j = 0; j < vt[i].nreq && j < req_addr_q.size(); j++) begin
                chk($sformatf("%s req%0d addr", nm, j), req_addr_q[j], vt[i].ra[j]);
                chk($sformatf("%s req%0d len", nm, j), 32'(req_len_q[j]), 32'(vt[i].rl[j]));
            end
            chk_pushes(nm, vt[i].addr, vt[i].npush);
            chk({nm, " err"}, 32'(last_err), 32'(vt[i].err));
            chk({nm, " aborted"}, 32'(last_ab), 32'd0);
            chk({nm, " idle busy"}, 32'(busy_o), 32'd0);
        end

        // Zero-length descriptor completes with no requests.
        d0 = n_done;
        start_xfer(32'h7000, 0, 16, 0);
        c = 1;
        while (n_done == d0 && c < 6) begin tick(); c++; end
        chk("zero done", 32'(n_done - d0), 32'd1);
        chk("zero latency<=2", 32'(c <= 2), 32'd1);
        chk("zero nreq", 32'(req_addr_q.size()), 32'd0);
        chk("zero err", 32'(last_err), 32'd0);
        tick();

        // FIFO space gating; a second start while busy must be ignored.
        d0 = n_done;
        start_xfer(32'h4000, 8, 3, 0);
        src_addr_i = 32'h9000; start_i = 1'b1; tick(); start_i = 1'b0;
        repeat (8) tick();
        chk("space noreq", 32'(req_addr_q.size()), 32'd0);
        chk("space reqv", 32'(rd_req_valid_o), 32'd0);
        chk("space busy", 32'(busy_o), 32'd1);
        fifo_free_i = 5'd8;
        tick();
        chk("space reqv after", 32'(rd_req_valid_o), 32'd1);
        chk("space req addr", rd_req_addr_o, 32'h4000);
        wait_done("space", d0, 100);
        chk_pushes("space", 32'h4000, 8);
        tick();

        // Abort while waiting for FIFO space.
        d0 = n_done;
        start_xfer(32'h4000, 8, 3, 0);
        repeat (3) tick();
        abort_i = 1'b1; tick(); abort_i = 1'b0;
        c = 1;
        while (n_done == d0 && c < 6) begin tick(); c++; end
        chk("abw done<=2", 32'(n_done != d0 && c <= 2), 32'd1);
        chk("abw aborted", 32'(last_ab), 32'd1);
        chk("abw nreq", 32'(req_addr_q.size()), 32'd0);
        tick();

        // Abort during DATA: current burst completes, no more requests.
        d0 = n_done;
        start_xfer(32'h5000, 24, 16, 0);
        c = 0;
        while (push_q.size() == 0 && c < 50) begin tick(); c++; end
        abort_i = 1'b1; tick(); abort_i = 1'b0;
        wait_done("abd", d0, 100);
        repeat (4) tick();
        chk("abd nreq", 32'(req_addr_q.size()), 32'd1);
        chk_pushes("abd", 32'h5000, 8);
        chk("abd aborted", 32'(last_ab), 32'd1);
        chk("abd err", 32'(last_err), 32'd0);

        // Reset in the middle of a burst.
        start_xfer(32'h6000, 16, 16, 0);
        c = 0;
        while (push_q.size() < 2 && c < 50) begin tick(); c++; end
        rst = 1'b1;
        tick();
        chk("rst busy", 32'(busy_o), 32'd0);
        chk("rst reqv", 32'(rd_req_valid_o), 32'd0);
        chk("rst fifow", 32'(fifo_write_o), 32'd0);
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
